// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus-master driver: I/O register map,
// FSM state encodings, baud table and the baud-divisor helper.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int FIFO_DEPTH = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_PROG_LO  = 3'd0;
    localparam state_t S_PROG_HI  = 3'd1;
    localparam state_t S_IDLE     = 3'd2;
    localparam state_t S_READ     = 3'd3;
    localparam state_t S_WAIT_TBR = 3'd4;
    localparam state_t S_WRITE    = 3'd5;
    localparam state_t S_GUARD    = 3'd6;

    function automatic int unsigned baud_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return 4800;
            2'b01:   return 9600;
            2'b10:   return 19200;
            default: return 38400;
        endcase
    endfunction

    // Only ever called with constant arguments, so it folds away at elaboration.
    function automatic logic [15:0] calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        int unsigned q;
        q = clk_hz / (16 * baud) - 1;
        return q[15:0];
    endfunction

endpackage

// File: rtl/spart_drv_fifo.sv
// 4x8 synchronous FIFO buffering echoed bytes between READ and WRITE
// (only instantiated when SPART_DRV_FIFO_EN is defined).
module spart_drv_fifo
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    logic [7:0] mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       push_ok;
    logic       pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign empty   = (count == 3'd0);
    assign full    = (count == 3'(FIFO_DEPTH));
    assign dout    = mem[rd_ptr];

    // NOTE: storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop_ok)  rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes RX bytes.
// Define SPART_DRV_FIFO_EN to buffer up to four bytes between reads and writes.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned GUARD_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    output logic [7:0] echo_cnt
);

    localparam logic [15:0] DIV_0 = calc_div(CLK_HZ, baud_of(2'd0));
    localparam logic [15:0] DIV_1 = calc_div(CLK_HZ, baud_of(2'd1));
    localparam logic [15:0] DIV_2 = calc_div(CLK_HZ, baud_of(2'd2));
    localparam logic [15:0] DIV_3 = calc_div(CLK_HZ, baud_of(2'd3));
    localparam logic [1:0]  GUARD_LAST = 2'(GUARD_CYC - 1);

    state_t      state, state_nx;
    state_t      ret, ret_nx;
    logic [1:0]  gcnt, gcnt_nx;
    logic [1:0]  cfg_meta, cfg_sync, cfg_q, cfg_nx;
    logic [15:0] div_nx;
    logic [7:0]  wr_byte;
    logic [7:0]  dout, dout_nx;
    logic        iocs_nx, iorw_nx;
    logic [1:0]  ioaddr_nx;

    assign databus = (iocs && !iorw) ? dout : 8'bz;

`ifdef SPART_DRV_FIFO_EN
    logic fifo_empty;
    logic fifo_full;

    spart_drv_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (state == S_READ),
        .din   (databus),
        .pop   (state == S_WRITE),
        .dout  (wr_byte),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
`else
    logic [7:0] rx_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  rx_byte <= '0;
        else if (state == S_READ) rx_byte <= databus;
    end

    assign wr_byte = rx_byte;
`endif

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        ret_nx   = ret;
        gcnt_nx  = gcnt;
        cfg_nx   = cfg_q;
        case (state)
            // Bus outputs are registered, so after reset PROG_LO waits one
            // cycle for its own access to appear before moving on.
            S_PROG_LO: if (iocs) state_nx = S_PROG_HI;
            S_PROG_HI: begin
                state_nx = S_GUARD;
                ret_nx   = S_IDLE;
                gcnt_nx  = GUARD_LAST;
            end
            S_IDLE: begin
`ifdef SPART_DRV_FIFO_EN
                if (cfg_sync != cfg_q) begin
                    if (fifo_empty) begin
                        cfg_nx   = cfg_sync;
                        state_nx = S_PROG_LO;
                    end else if (tbr) begin
                        state_nx = S_WRITE;
                    end
                end else if (rda && !fifo_full) begin
                    state_nx = S_READ;
                end else if (tbr && !fifo_empty) begin
                    state_nx = S_WRITE;
                end
`else
                if (cfg_sync != cfg_q) begin
                    cfg_nx   = cfg_sync;
                    state_nx = S_PROG_LO;
                end else if (rda) begin
                    state_nx = S_READ;
                end
`endif
            end
            S_READ: begin
                state_nx = S_GUARD;
`ifdef SPART_DRV_FIFO_EN
                ret_nx   = S_IDLE;
`else
                ret_nx   = S_WAIT_TBR;
`endif
                gcnt_nx  = GUARD_LAST;
            end
            S_WAIT_TBR: if (tbr) state_nx = S_WRITE;
            S_WRITE: begin
                state_nx = S_GUARD;
                ret_nx   = S_IDLE;
                gcnt_nx  = GUARD_LAST;
            end
            S_GUARD: begin
                if (gcnt == 2'd0) state_nx = ret;
                else              gcnt_nx  = gcnt - 2'd1;
            end
            default: state_nx = S_PROG_LO;
        endcase
    end

    always_comb begin
        case (cfg_nx)
            2'b00:   div_nx = DIV_0;
            2'b01:   div_nx = DIV_1;
            2'b10:   div_nx = DIV_2;
            default: div_nx = DIV_3;
        endcase
    end

    // Bus outputs are decoded from the next state so each access is a clean register.
    always_comb begin
        iocs_nx   = 1'b0;
        iorw_nx   = 1'b1;
        ioaddr_nx = ADDR_DATA;
        dout_nx   = 8'h00;
        case (state_nx)
            S_PROG_LO: begin
                iocs_nx   = 1'b1;
                iorw_nx   = 1'b0;
                ioaddr_nx = ADDR_DB_LO;
                dout_nx   = div_nx[7:0];
            end
            S_PROG_HI: begin
                iocs_nx   = 1'b1;
                iorw_nx   = 1'b0;
                ioaddr_nx = ADDR_DB_HI;
                dout_nx   = div_nx[15:8];
            end
            S_READ: iocs_nx = 1'b1;
            S_WRITE: begin
                iocs_nx = 1'b1;
                iorw_nx = 1'b0;
                dout_nx = wr_byte;
            end
            default: iocs_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_PROG_LO;
            ret      <= S_IDLE;
            gcnt     <= '0;
            cfg_meta <= '0;
            cfg_sync <= '0;
            cfg_q    <= '0;
            iocs     <= 1'b0;
            iorw     <= 1'b1;
            ioaddr   <= ADDR_DATA;
            dout     <= '0;
            echo_cnt <= '0;
        end else begin
            state    <= state_nx;
            ret      <= ret_nx;
            gcnt     <= gcnt_nx;
            cfg_meta <= br_cfg;
            cfg_sync <= cfg_meta;
            cfg_q    <= cfg_nx;
            iocs     <= iocs_nx;
            iorw     <= iorw_nx;
            ioaddr   <= ioaddr_nx;
            dout     <= dout_nx;
            if (state == S_WRITE) echo_cnt <= echo_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver: stimulus queues expected bus accesses,
// a negedge monitor pops and compares each access the DUT issues.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] echo_cnt;
    logic [7:0] rx_val;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_acc = -100;

    typedef struct {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
        int         at;
        int         gap;
    } acc_t;

    acc_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bus model: the SPART answers reads with the current RX byte.
    assign databus = (iocs && iorw) ? rx_val : 8'bz;

    spart_driver dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr),
        .echo_cnt (echo_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_acc(input logic rw, input logic [1:0] addr, input logic [7:0] data,
                            input int at, input int gap);
        acc_t e;
        e.rw   = rw;
        e.addr = addr;
        e.data = data;
        e.at   = at;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_read();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick(1);
            if (iocs && iorw) seen = 1'b1;
        end
        rda = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL read_timeout: no read access within 100 cycles (cycle %0d)", cyc);
        end
        tick(1);
    endtask

    task automatic deliver(input logic [7:0] b);
        rx_val = b;
        rda    = 1'b1;
        wait_read();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        tick(4);
        check("drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin : monitor
        acc_t e;
        if (!rst && iocs) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access: rw=%0b addr=%0d data=0x%0h, nothing expected (cycle %0d)",
                         iorw, ioaddr, databus, cyc);
            end else begin
                e = exp_q.pop_front();
                check("acc_rw", 32'(iorw), 32'(e.rw));
                check("acc_addr", 32'(ioaddr), 32'(e.addr));
                if (!e.rw)     check("acc_data", 32'(databus), 32'(e.data));
                if (e.at >= 0) check("acc_cycle", 32'(cyc), 32'(e.at));
                if (e.gap >= 0) check("acc_gap", 32'(cyc - last_acc), 32'(e.gap));
            end
            last_acc = cyc;
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        br_cfg = 2'b01;
        rda    = 1'b0;
        tbr    = 1'b0;
        rx_val = 8'h00;
        rst    = 1'b1;
        tick(3);
        check("rst_iocs", 32'(iocs), 32'd0);
        check("rst_iorw", 32'(iorw), 32'd1);
        check("rst_ioaddr", 32'(ioaddr), 32'd0);
        check("rst_echo", 32'(echo_cnt), 32'd0);

        // Synchroniser starts at 00 (4800 baud: 1301), then the 9600 setting (650) follows.
        push_acc(1'b0, 2'b10, 8'h15, -1, -1);
        push_acc(1'b0, 2'b11, 8'h05, -1, 1);
        push_acc(1'b0, 2'b10, 8'h8A, -1, -1);
        push_acc(1'b0, 2'b11, 8'h02, -1, 1);
        rst = 1'b0;
        wait_drain();
        check("idle_iocs", 32'(iocs), 32'd0);

        // Single echo with tbr already high: read 1 cycle after rda, write 3 after read.
        tbr = 1'b1;
        push_acc(1'b1, 2'b00, 8'h00, cyc + 1, -1);
        push_acc(1'b0, 2'b00, 8'h5A, -1, 3);
        deliver(8'h5A);
        wait_drain();
        check("echo_1", 32'(echo_cnt), 32'd1);

        // tbr held low: no write until it rises, then exactly one cycle later.
        tbr = 1'b0;
        push_acc(1'b1, 2'b00, 8'h00, cyc + 1, -1);
        deliver(8'hC3);
        tick(50);
        push_acc(1'b0, 2'b00, 8'hC3, cyc + 1, -1);
        tbr = 1'b1;
        wait_drain();
        check("echo_2", 32'(echo_cnt), 32'd2);

        // br_cfg change during WAIT_TBR: echo completes, then divisor 161 = 0x00A1.
        tbr = 1'b0;
        push_acc(1'b1, 2'b00, 8'h00, -1, -1);
        deliver(8'h7E);
        tick(4);
        br_cfg = 2'b11;
        tick(10);
        push_acc(1'b0, 2'b00, 8'h7E, cyc + 1, -1);
        push_acc(1'b0, 2'b10, 8'hA1, -1, -1);
        push_acc(1'b0, 2'b11, 8'h00, -1, 1);
        tbr = 1'b1;
        wait_drain();
        check("echo_3", 32'(echo_cnt), 32'd3);

        // cfg change and rda seen in the same IDLE cycle: reprogram (324 = 0x0144) first.
        push_acc(1'b0, 2'b10, 8'h44, -1, -1);
        push_acc(1'b0, 2'b11, 8'h01, -1, 1);
        push_acc(1'b1, 2'b00, 8'h00, -1, -1);
        push_acc(1'b0, 2'b00, 8'h33, -1, 3);
        br_cfg = 2'b10;
        tick(2);
        deliver(8'h33);
        wait_drain();
        check("echo_4", 32'(echo_cnt), 32'd4);

        // Reset asserted during a WRITE cycle.
        tbr = 1'b0;
        push_acc(1'b1, 2'b00, 8'h00, -1, -1);
        deliver(8'h99);
        tick(4);
        wait_drain();
        tbr = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick(1);
                if (iocs && !iorw) seen = 1'b1;
            end
            rst = 1'b1;
            #1;
            check("write_seen", 32'(seen), 32'd1);
        end
        check("midrst_iocs", 32'(iocs), 32'd0);
        check("midrst_iorw", 32'(iorw), 32'd1);
        check("midrst_ioaddr", 32'(ioaddr), 32'd0);
        check("midrst_echo", 32'(echo_cnt), 32'd0);
        tbr = 1'b0;
        push_acc(1'b0, 2'b10, 8'h15, -1, -1);
        push_acc(1'b0, 2'b11, 8'h05, -1, 1);
        push_acc(1'b0, 2'b10, 8'h44, -1, -1);
        push_acc(1'b0, 2'b11, 8'h01, -1, 1);
        tick(2);
        rst = 1'b0;
        wait_drain();
        check("post_rst_echo", 32'(echo_cnt), 32'd0);

        // Counter wrap: 255 echoes, then one more wraps to 0.
        tbr = 1'b1;
        for (int i = 0; i < 255; i++) begin
            push_acc(1'b1, 2'b00, 8'h00, -1, -1);
            push_acc(1'b0, 2'b00, 8'(i), -1, 3);
            deliver(8'(i));
        end
        wait_drain();
        check("echo_255", 32'(echo_cnt), 32'd255);
        push_acc(1'b1, 2'b00, 8'h00, -1, -1);
        push_acc(1'b0, 2'b00, 8'hEE, -1, 3);
        deliver(8'hEE);
        wait_drain();
        check("echo_wrap", 32'(echo_cnt), 32'd0);

`ifdef SPART_DRV_FIFO_EN
        // Four bytes fill the FIFO, the fifth rda is ignored until a pop.
        tbr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_acc(1'b1, 2'b00, 8'h00, -1, -1);
            deliver(8'(i));
        end
        tick(10);
        rx_val = 8'h05;
        rda    = 1'b1;
        tick(30);
        push_acc(1'b0, 2'b00, 8'h01, -1, -1);
        push_acc(1'b1, 2'b00, 8'h00, -1, -1);
        push_acc(1'b0, 2'b00, 8'h02, -1, -1);
        push_acc(1'b0, 2'b00, 8'h03, -1, -1);
        push_acc(1'b0, 2'b00, 8'h04, -1, -1);
        push_acc(1'b0, 2'b00, 8'h05, -1, -1);
        tbr = 1'b1;
        wait_read();
        wait_drain();
        check("fifo_echo", 32'(echo_cnt), 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
